load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports in this order:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  asynchronous active-high reset.
REQ-002 Pipeline-side ports SHALL be:
- i_memReq  in  1  current instruction is load/store.
- i_memWrite  in  1  1 = store, 0 = load.
- i_funct3  in  3  [1:0] size (00 byte, 01 half, 10/11 word); [2] = 1 zero-extend, 0 sign-extend.
- i_addr  in  32  byte address from ALU.
- i_storeData  in  32  rs2 value.
- o_stall  out  1  hold pipeline.
- o_loadData  out  32  extended load result.
- o_loadValid  out  1  one-cycle pulse, o_loadData valid.
- o_misaligned  out  1  misaligned access flag.
REQ-003 Data-memory-side ports SHALL be:
- o_dmemReq  out  1  access request.
- o_dmemWrite  out  1  write strobe.
- o_dmemAddr  out  32  word address, bits [1:0] = 0.
- o_dmemWdata  out  32  lane-replicated store data.
- o_dmemByteEn  out  4  byte lane enables.
- i_dmemReady  in  1  access complete this cycle.
- i_dmemRdata  in  32  read word, valid with i_dmemReady.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-005 IDLE -> ACCESS SHALL occur when i_memReq=1 and the access is not misaligned; on that edge the block SHALL capture address, size, extend mode, write flag, byte enables and write data.
REQ-006 ACCESS SHALL hold o_dmemReq=1 with stable registered outputs until i_dmemReady=1, then go to DONE; no timeout.
REQ-007 DONE SHALL last exactly one cycle, drive o_loadValid=1 for loads (0 for stores), ignore i_memReq, and go to IDLE.
REQ-008 o_stall SHALL be 1 in ACCESS, 1 in IDLE when i_memReq=1 and not misaligned (combinational), and 0 otherwise, including in DONE.
REQ-009 Load latency SHALL be: request cycle, then >=1 ACCESS cycle(s), then DONE. With i_dmemReady tied high, o_loadValid rises 2 cycles after the request cycle.
REQ-010 Byte store: o_dmemByteEn = 4'b0001 << addr[1:0]; wdata = byte replicated x4.
REQ-011 Half store: byte enable = 4'b0011 << (2*addr[1]); wdata = half replicated x2.
REQ-012 Word store: byte enable = 4'b1111.
REQ-013 Loads SHALL drive o_dmemByteEn = 4'b0000 and o_dmemWrite = 0.
REQ-014 Load data SHALL select the lane indicated by the captured addr[1:0] (byte) or addr[1] (half) and sign- or zero-extend to 32 bits per funct3[2]. The value is registered on the ACCESS->DONE edge and holds until the next load completes.
REQ-015 o_misaligned SHALL be combinational and high when i_memReq=1 in IDLE and either half with addr[0]=1, or word with addr[1:0]!=0. No access starts and o_stall stays 0.

Reset
REQ-016 Reset SHALL asynchronously force IDLE, with o_dmemReq=0, o_dmemWrite=0, o_dmemAddr=0, o_dmemWdata=0, o_dmemByteEn=0, o_loadData=0, o_loadValid=0, o_stall=0.
REQ-017 Reset during ACCESS SHALL abandon the access; o_dmemReq drops without waiting for the clock.

Configuration
REQ-018 Macro LSU_MISALIGN_CHECK_EN:
- Defined: REQ-015 applies.
- Undefined: o_misaligned is tied 0, and address low bits below the access size are ignored (half uses addr[1], word uses lane 0); every request starts an access.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Store byte 0xA5 to 0x1003, ready after 3 cycles -> dmemAddr 0x1000, byteEn 1000, wdata 0xA5A5A5A5, stall high 4 cycles.
- Signed LB from 0x2001, rdata 0x00008000, ready immediate -> loadData 0xFFFFFF80, loadValid one pulse 2 cycles after request. Same access with funct3=100 -> loadData 0x00000080.
- LH from 0x2002, rdata 0xBEEF1234, signed -> loadData 0xFFFFBEEF.
- LW from 0x3002 with macro defined -> misaligned=1, dmemReq never asserted, stall 0. With macro undefined -> access to 0x3000, byteEn 0000.
- Back-to-back loads, memReq held high through DONE -> exactly one access per instruction, no duplicate request in DONE.
- i_rst pulsed mid-ACCESS -> dmemReq low asynchronously, state IDLE, loadValid never asserted.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: aligns pipeline loads/stores onto a word-wide data memory port.
// Latency: request cycle, >=1 ACCESS cycle(s) until i_dmemReady, then one DONE cycle (load result 2 cycles after request at best).
// Backpressure: o_stall holds the pipeline while an access is starting or in flight; memory stalls by withholding i_dmemReady.
// Build option: define LSU_MISALIGN_CHECK_EN to flag and refuse misaligned half/word accesses.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_memReq,
  input  logic        i_memWrite,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_storeData,
  output logic        o_stall,
  output logic [31:0] o_loadData,
  output logic        o_loadValid,
  output logic        o_misaligned,
  output logic        o_dmemReq,
  output logic        o_dmemWrite,
  output logic [31:0] o_dmemAddr,
  output logic [31:0] o_dmemWdata,
  output logic [3:0]  o_dmemByteEn,
  input  logic        i_dmemReady,
  input  logic [31:0] i_dmemRdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [1:0]  size_q;    // captured access size
  logic        zext_q;    // captured extend mode, 1 = zero-extend
  logic [1:0]  lane_q;    // captured address low bits for lane selection

  logic        start;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

`ifdef LSU_MISALIGN_CHECK_EN
  logic mis_raw;
  // half needs addr[0]=0, word needs addr[1:0]=0; only meaningful while a request waits in IDLE
  assign mis_raw      = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                        (i_funct3[1] & (i_addr[1:0] != 2'b00));
  assign o_misaligned = (state == IDLE) & i_memReq & mis_raw;
`else
  // low address bits below the access size are simply ignored
  assign o_misaligned = 1'b0;
`endif

  assign start   = (state == IDLE) & i_memReq & ~o_misaligned;
  assign o_stall = (state == ACCESS) | start;

  // Byte enables and lane-replicated write data for the incoming request
  always_comb begin
    req_be    = 4'b0000;
    req_wdata = i_storeData;
    case (i_funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << i_addr[1:0];
        req_wdata = {4{i_storeData[7:0]}};
      end
      2'b01: begin
        req_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{i_storeData[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = i_storeData;
      end
    endcase
    if (!i_memWrite) req_be = 4'b0000;
  end

  // Lane select and sign/zero extension of the returning read word
  always_comb begin
    byte_sel = i_dmemRdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? i_dmemRdata[31:16] : i_dmemRdata[15:0];
    case (size_q)
      2'b00:   load_ext = zext_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = zext_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = i_dmemRdata;
    endcase
  end

  // Access FSM with registered memory-side and load-result outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      size_q       <= 2'b00;
      zext_q       <= 1'b0;
      lane_q       <= 2'b00;
      o_dmemReq    <= 1'b0;
      o_dmemWrite  <= 1'b0;
      o_dmemAddr   <= 32'h0;
      o_dmemWdata  <= 32'h0;
      o_dmemByteEn <= 4'b0000;
      o_loadData   <= 32'h0;
      o_loadValid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= ACCESS;
            size_q       <= i_funct3[1:0];
            zext_q       <= i_funct3[2];
            lane_q       <= i_addr[1:0];
            o_dmemReq    <= 1'b1;
            o_dmemWrite  <= i_memWrite;
            o_dmemAddr   <= {i_addr[31:2], 2'b00};
            o_dmemWdata  <= req_wdata;
            o_dmemByteEn <= req_be;
          end
        end
        ACCESS: begin
          if (i_dmemReady) begin
            state        <= DONE;
            o_dmemReq    <= 1'b0;
            o_dmemWrite  <= 1'b0;
            o_dmemByteEn <= 4'b0000;
            // o_dmemWrite still holds the captured store flag here
            if (!o_dmemWrite) begin
              o_loadData  <= load_ext;
              o_loadValid <= 1'b1;
            end
          end
        end
        DONE: begin
          // one-cycle completion; any pending i_memReq waits for IDLE
          o_loadValid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected memory accesses
// and load results into a queue; an independent monitor pops and compares them.
// Works with or without LSU_MISALIGN_CHECK_EN defined.
module tb_load_store_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_memReq;
  logic        i_memWrite;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_storeData;
  logic        o_stall;
  logic [31:0] o_loadData;
  logic        o_loadValid;
  logic        o_misaligned;
  logic        o_dmemReq;
  logic        o_dmemWrite;
  logic [31:0] o_dmemAddr;
  logic [31:0] o_dmemWdata;
  logic [3:0]  o_dmemByteEn;
  logic        i_dmemReady;
  logic [31:0] i_dmemRdata;

  load_store_unit dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_memReq(i_memReq), .i_memWrite(i_memWrite), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_storeData(i_storeData),
    .o_stall(o_stall), .o_loadData(o_loadData), .o_loadValid(o_loadValid),
    .o_misaligned(o_misaligned),
    .o_dmemReq(o_dmemReq), .o_dmemWrite(o_dmemWrite), .o_dmemAddr(o_dmemAddr),
    .o_dmemWdata(o_dmemWdata), .o_dmemByteEn(o_dmemByteEn),
    .i_dmemReady(i_dmemReady), .i_dmemRdata(i_dmemRdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          is_result;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_access(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata);
    exp_t e;
    e.is_result = 1'b0; e.wr = wr; e.addr = addr; e.be = be; e.wdata = wdata; e.data = 32'h0;
    sb_q.push_back(e);
  endtask

  task automatic push_result(input logic [31:0] data);
    exp_t e;
    e.is_result = 1'b1; e.wr = 1'b0; e.addr = 32'h0; e.be = 4'h0; e.wdata = 32'h0; e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: every accepted memory access and every load completion is matched in order
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst) begin
      if (o_dmemReq && i_dmemReady) begin
        if (sb_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL mon_unexpected_access: got addr %h, expected no access", o_dmemAddr);
        end else begin
          e = sb_q.pop_front();
          chk("mon_kind_access", {31'h0, e.is_result}, 32'h0);
          chk("mon_addr", o_dmemAddr, e.addr);
          chk("mon_byteen", {28'h0, o_dmemByteEn}, {28'h0, e.be});
          chk("mon_write", {31'h0, o_dmemWrite}, {31'h0, e.wr});
          if (e.wr) chk("mon_wdata", o_dmemWdata, e.wdata);
        end
      end
      if (o_loadValid) begin
        if (sb_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL mon_unexpected_load: got data %h, expected no loadValid", o_loadData);
        end else begin
          e = sb_q.pop_front();
          chk("mon_kind_result", {31'h0, e.is_result}, 32'h1);
          chk("mon_loaddata", o_loadData, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Cycle 0 is the request cycle; memory answers in cycle rdy_after; loop ends on the DONE cycle
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int rdy_after,
                         input bit hold, output int stall_cnt, output int lv_cyc,
                         output int acc_cnt, output int req_cnt, output logic mis0);
    stall_cnt = 0; lv_cyc = -1; acc_cnt = 0; req_cnt = 0; mis0 = 1'b0;
    i_memWrite = wr; i_funct3 = f3; i_addr = a; i_storeData = sd;
    for (int c = 0; c < rdy_after + 2; c++) begin
      i_memReq    = (c == 0) || hold;
      i_dmemReady = (c == rdy_after);
      i_dmemRdata = (c == rdy_after) ? rd : 32'hDEADBEEF;
      @(negedge i_clk);
      if (c == 0) mis0 = o_misaligned;
      if (o_stall) stall_cnt++;
      if (o_dmemReq) req_cnt++;
      if (o_dmemReq && i_dmemReady) acc_cnt++;
      if (o_loadValid && lv_cyc < 0) lv_cyc = c;
      cyc();
    end
    i_memReq = 1'b0; i_dmemReady = 1'b0;
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    int   st, lv, acc, rq, lvc;
    logic mis;
    i_rst = 1'b1; i_memReq = 1'b0; i_memWrite = 1'b0; i_funct3 = 3'b000;
    i_addr = 32'h0; i_storeData = 32'h0; i_dmemReady = 1'b0; i_dmemRdata = 32'h0;

    // Reset state
    @(negedge i_clk);
    chk("rst_dmemReq",   {31'h0, o_dmemReq}, 32'h0);
    chk("rst_dmemWrite", {31'h0, o_dmemWrite}, 32'h0);
    chk("rst_dmemAddr",  o_dmemAddr, 32'h0);
    chk("rst_dmemWdata", o_dmemWdata, 32'h0);
    chk("rst_byteEn",    {28'h0, o_dmemByteEn}, 32'h0);
    chk("rst_loadData",  o_loadData, 32'h0);
    chk("rst_loadValid", {31'h0, o_loadValid}, 32'h0);
    chk("rst_stall",     {31'h0, o_stall}, 32'h0);
    cyc();
    i_rst = 1'b0;
    cyc();

    // Store byte 0xA5 to 0x1003, memory ready on the third ACCESS cycle
    push_access(1'b1, 32'h1000, 4'b1000, 32'hA5A5A5A5);
    run_req(1'b1, 3'b000, 32'h1003, 32'h123456A5, 32'h0, 3, 1'b0, st, lv, acc, rq, mis);
    chk("sb_stall_cycles", st, 4);
    chk("sb_no_loadValid", lv, -1);
    chk("sb_access_count", acc, 1);

    // Signed LB from 0x2001, ready immediately
    push_access(1'b0, 32'h2000, 4'b0000, 32'h0);
    push_result(32'hFFFFFF80);
    run_req(1'b0, 3'b000, 32'h2001, 32'h0, 32'h00008000, 1, 1'b0, st, lv, acc, rq, mis);
    chk("lb_loadValid_cycle", lv, 2);
    chk("lb_stall_cycles", st, 2);

    // Same access, zero-extended
    push_access(1'b0, 32'h2000, 4'b0000, 32'h0);
    push_result(32'h00000080);
    run_req(1'b0, 3'b100, 32'h2001, 32'h0, 32'h00008000, 1, 1'b0, st, lv, acc, rq, mis);
    chk("lbu_loadValid_cycle", lv, 2);

    // Signed LH from upper half, two ACCESS cycles
    push_access(1'b0, 32'h2000, 4'b0000, 32'h0);
    push_result(32'hFFFFBEEF);
    run_req(1'b0, 3'b001, 32'h2002, 32'h0, 32'hBEEF1234, 2, 1'b0, st, lv, acc, rq, mis);
    chk("lh_loadValid_cycle", lv, 3);
    chk("lh_stall_cycles", st, 3);

    // LHU from lower half
    push_access(1'b0, 32'h2000, 4'b0000, 32'h0);
    push_result(32'h00008234);
    run_req(1'b0, 3'b101, 32'h2000, 32'h0, 32'hBEEF8234, 1, 1'b0, st, lv, acc, rq, mis);

    // SH to 0x2006 and SW to 0x4000; load result must hold across stores
    push_access(1'b1, 32'h2004, 4'b1100, 32'hCAFECAFE);
    run_req(1'b1, 3'b001, 32'h2006, 32'h0000CAFE, 32'h0, 1, 1'b0, st, lv, acc, rq, mis);
    push_access(1'b1, 32'h4000, 4'b1111, 32'h12345678);
    run_req(1'b1, 3'b010, 32'h4000, 32'h12345678, 32'h0, 1, 1'b0, st, lv, acc, rq, mis);
    chk("loaddata_hold", o_loadData, 32'h00008234);

    // LW from 0x3002
`ifdef LSU_MISALIGN_CHECK_EN
    i_memReq = 1'b1; i_memWrite = 1'b0; i_funct3 = 3'b010; i_addr = 32'h3002;
    @(negedge i_clk);
    chk("mis_flag", {31'h0, o_misaligned}, 32'h1);
    chk("mis_stall", {31'h0, o_stall}, 32'h0);
    rq = 0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      @(negedge i_clk);
      if (o_dmemReq) rq++;
    end
    chk("mis_no_dmemReq", rq, 0);
    cyc();
    i_memReq = 1'b0;
    cyc();
`else
    push_access(1'b0, 32'h3000, 4'b0000, 32'h0);
    push_result(32'hCAFEF00D);
    run_req(1'b0, 3'b010, 32'h3002, 32'h0, 32'hCAFEF00D, 1, 1'b0, st, lv, acc, rq, mis);
    chk("nomis_flag", {31'h0, mis}, 32'h0);
    chk("nomis_access_count", acc, 1);
`endif

    // Back-to-back loads with memReq held high through DONE
    push_access(1'b0, 32'h5000, 4'b0000, 32'h0);
    push_result(32'h11223344);
    push_access(1'b0, 32'h5000, 4'b0000, 32'h0);
    push_result(32'h000000AB);
    run_req(1'b0, 3'b010, 32'h5000, 32'h0, 32'h11223344, 1, 1'b1, st, lv, acc, rq, mis);
    chk("b2b1_access_count", acc, 1);
    chk("b2b1_req_cycles", rq, 1);
    chk("b2b1_stall_cycles", st, 2);
    run_req(1'b0, 3'b100, 32'h5003, 32'h0, 32'hAB000000, 1, 1'b1, st, lv, acc, rq, mis);
    chk("b2b2_access_count", acc, 1);
    chk("b2b2_req_cycles", rq, 1);
    chk("b2b2_loadValid_cycle", lv, 2);
    @(negedge i_clk);
    chk("b2b_idle_dmemReq", {31'h0, o_dmemReq}, 32'h0);
    cyc();

    // Reset pulsed mid-ACCESS
    i_memReq = 1'b1; i_memWrite = 1'b0; i_funct3 = 3'b000; i_addr = 32'h6001;
    i_dmemReady = 1'b0;
    cyc();
    i_memReq = 1'b0;
    @(negedge i_clk);
    chk("rstmid_dmemReq_before", {31'h0, o_dmemReq}, 32'h1);
    #2 i_rst = 1'b1;
    #1;
    chk("rstmid_dmemReq_async", {31'h0, o_dmemReq}, 32'h0);
    chk("rstmid_stall", {31'h0, o_stall}, 32'h0);
    cyc();
    cyc();
    i_rst = 1'b0;
    lvc = 0; rq = 0;
    for (int c = 0; c < 4; c++) begin
      i_dmemReady = 1'b1;
      @(negedge i_clk);
      if (o_loadValid) lvc++;
      if (o_dmemReq) rq++;
      cyc();
    end
    i_dmemReady = 1'b0;
    chk("rstmid_no_loadValid", lvc, 0);
    chk("rstmid_idle_no_req", rq, 0);

    cyc();
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
